// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and digit correction helper for the binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} bcd_state_t;

    localparam int DIGIT_W = 4;

    function automatic logic [DIGIT_W-1:0] add3_adj(input logic [DIGIT_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational add-3 correction for one BCD digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = add3_adj(digit_i);

endmodule

// File: rtl/bin2bcd_stream.sv
// rtl/bin2bcd_stream.sv - bit-serial shift-and-add-3 binary-to-BCD converter with valid/ready on both sides
module bin2bcd_stream
    import bcd_pkg::*;
#(
    parameter int BIN_W       = 16,
    parameter int DIGITS      = 5,
    parameter int SIGNED_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BIN_W-1:0]          bin_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DIGIT_W*DIGITS-1:0] dec_out,
    output logic                      neg,
    output logic                      ovf,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin2bcd_stream: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $error("bin2bcd_stream: DIGITS=%0d outside 1..10", DIGITS);
    end

    bcd_state_t        state_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BIN_W-1:0]  mag_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_acc_q;
    logic              ovf_acc_q;
    logic [BCD_W-1:0]  dec_q;
    logic              neg_q;
    logic              ovf_q;

    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_d;
    logic [BIN_W-1:0]  mag_d;
    logic [BIN_W-1:0]  bin_neg;
    logic [BIN_W-1:0]  mag_in;
    logic              sign_in;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (bcd_q[DIGIT_W*g +: DIGIT_W]),
            .digit_o (bcd_adj[DIGIT_W*g +: DIGIT_W])
        );
    end

    // The magnitude is kept unsigned at BIN_W bits so the most negative value negates to itself and still converts.
    assign bin_neg = -bin_in;
    assign sign_in = (SIGNED_MODE != 0) && bin_in[BIN_W-1];
    assign mag_in  = sign_in ? bin_neg : bin_in;

    assign bcd_d = {bcd_adj[BCD_W-2:0], mag_q[BIN_W-1]};
    assign mag_d = {mag_q[BIN_W-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            mag_q     <= '0;
            cnt_q     <= '0;
            neg_acc_q <= 1'b0;
            ovf_acc_q <= 1'b0;
            dec_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mag_q     <= mag_in;
                        neg_acc_q <= sign_in;
                        bcd_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        cnt_q     <= CNT_W'(BIN_W);
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    if (cnt_q != '0) begin
                        bcd_q     <= bcd_d;
                        mag_q     <= mag_d;
                        cnt_q     <= cnt_q - CNT_W'(1);
                        ovf_acc_q <= ovf_acc_q | bcd_adj[BCD_W-1];
                    end else begin
                        dec_q   <= bcd_q;
                        neg_q   <= neg_acc_q;
                        ovf_q   <= ovf_acc_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dec_out   = dec_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_stream.sv
// tb/tb_bin2bcd_stream.sv - three converter variants driven in lockstep and checked against an arithmetic model
module tb_bin2bcd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bin_in;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic        neg0, neg1, neg2;
    logic        ovf0, ovf1, ovf2;
    logic [19:0] dec0, dec2;
    logic [15:0] dec1;

    logic [19:0] dec_v [3];
    logic        neg_v [3];
    logic        ovf_v [3];
    logic        ir_v  [3];
    logic        ov_v  [3];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bin2bcd_stream #(.BIN_W(16), .DIGITS(5), .SIGNED_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .bin_in(bin_in), .in_valid(in_valid), .in_ready(in_ready0),
        .dec_out(dec0), .neg(neg0), .ovf(ovf0), .out_valid(out_valid0), .out_ready(out_ready)
    );
    bin2bcd_stream #(.BIN_W(16), .DIGITS(4), .SIGNED_MODE(0)) u_dut1 (
        .clk(clk), .rst(rst), .bin_in(bin_in), .in_valid(in_valid), .in_ready(in_ready1),
        .dec_out(dec1), .neg(neg1), .ovf(ovf1), .out_valid(out_valid1), .out_ready(out_ready)
    );
    bin2bcd_stream #(.BIN_W(16), .DIGITS(5), .SIGNED_MODE(1)) u_dut2 (
        .clk(clk), .rst(rst), .bin_in(bin_in), .in_valid(in_valid), .in_ready(in_ready2),
        .dec_out(dec2), .neg(neg2), .ovf(ovf2), .out_valid(out_valid2), .out_ready(out_ready)
    );

    always_comb begin
        dec_v[0] = dec0;
        dec_v[1] = {4'h0, dec1};
        dec_v[2] = dec2;
        neg_v[0] = neg0;  neg_v[1] = neg1;  neg_v[2] = neg2;
        ovf_v[0] = ovf0;  ovf_v[1] = ovf1;  ovf_v[2] = ovf2;
        ir_v[0]  = in_ready0;  ir_v[1] = in_ready1;  ir_v[2] = in_ready2;
        ov_v[0]  = out_valid0; ov_v[1] = out_valid1; ov_v[2] = out_valid2;
    end

    function automatic int digits_of(input int k);
        return (k == 1) ? 4 : 5;
    endfunction

    function automatic bit signed_of(input int k);
        return (k == 2);
    endfunction

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int magnitude(input logic [15:0] x, input bit sgn);
        return (sgn && x[15]) ? 65536 - int'(x) : int'(x);
    endfunction

    function automatic logic [19:0] model_dec(input logic [15:0] x, input int k);
        int m = magnitude(x, signed_of(k)) % pow10(digits_of(k));
        logic [19:0] r = '0;
        for (int i = 0; i < digits_of(k); i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input logic [15:0] x, input int k);
        return magnitude(x, signed_of(k)) >= pow10(digits_of(k));
    endfunction

    function automatic logic model_neg(input logic [15:0] x, input int k);
        return signed_of(k) && x[15];
    endfunction

    task automatic send_and_wait(input logic [15:0] x, input bit noise, output int lat);
        int guard = 0;
        while (!in_ready0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        bin_in   = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bin_in   = 16'($urandom);
        lat = 0;
        while (!out_valid0 && lat < 100) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                bin_in   = 16'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat >= 100) begin
            fails++;
            $display("FAIL wait_out_valid: got no out_valid within %0d cycles for input %h", lat, x);
        end
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; bin_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dec_v[k] !== 20'h0 || neg_v[k] !== 1'b0 || ovf_v[k] !== 1'b0 ||
                ov_v[k] !== 1'b0 || ir_v[k] !== 1'b1) begin
                fails++;
                $display("FAIL reset dut%0d: got dec=%h neg=%b ovf=%b ov=%b ir=%b, want 0 0 0 0 1",
                         k, dec_v[k], neg_v[k], ovf_v[k], ov_v[k], ir_v[k]);
            end
        end
    endtask

    task automatic test_examples();
        logic [15:0] vec [8];
        logic [19:0] e0 [8];
        logic [19:0] e1 [8];
        logic [19:0] e2 [8];
        logic        o1 [8];
        logic        n2 [8];
        int lat;
        vec = '{16'd0, 16'd65535, 16'd9999, 16'd12345, 16'd42, 16'h8000, 16'hFFFF, 16'h7FFF};
        e0  = '{20'h00000, 20'h65535, 20'h09999, 20'h12345, 20'h00042, 20'h32768, 20'h65535, 20'h32767};
        e1  = '{20'h00000, 20'h05535, 20'h09999, 20'h02345, 20'h00042, 20'h02768, 20'h05535, 20'h02767};
        e2  = '{20'h00000, 20'h00001, 20'h09999, 20'h12345, 20'h00042, 20'h32768, 20'h00001, 20'h32767};
        o1  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        n2  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            send_and_wait(vec[i], 1'b0, lat);
            checks++;
            if (lat !== 17) begin
                fails++;
                $display("FAIL latency input %h: got %0d cycles, want 17", vec[i], lat);
            end
            checks++;
            if (dec0 !== e0[i] || ovf0 !== 1'b0 || neg0 !== 1'b0) begin
                fails++;
                $display("FAIL example dut0 input %h: got dec=%h ovf=%b neg=%b, want %h 0 0",
                         vec[i], dec0, ovf0, neg0, e0[i]);
            end
            checks++;
            if (dec_v[1] !== e1[i] || ovf1 !== o1[i] || neg1 !== 1'b0) begin
                fails++;
                $display("FAIL example dut1 input %h: got dec=%h ovf=%b neg=%b, want %h %b 0",
                         vec[i], dec_v[1], ovf1, neg1, e1[i], o1[i]);
            end
            checks++;
            if (dec2 !== e2[i] || ovf2 !== 1'b0 || neg2 !== n2[i]) begin
                fails++;
                $display("FAIL example dut2 input %h: got dec=%h ovf=%b neg=%b, want %h 0 %b",
                         vec[i], dec2, ovf2, neg2, e2[i], n2[i]);
            end
            accept_result();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] x = 16'd48213;
        int lat;
        send_and_wait(x, 1'b0, lat);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                in_valid = 1'b1;
                bin_in   = 16'd777;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ov_v[k] !== 1'b1 || ir_v[k] !== 1'b0 || dec_v[k] !== model_dec(x, k)) begin
                    fails++;
                    $display("FAIL backpressure dut%0d cycle %0d: got ov=%b ir=%b dec=%h, want 1 0 %h",
                             k, c, ov_v[k], ir_v[k], dec_v[k], model_dec(x, k));
                end
            end
        end
        accept_result();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov_v[k] !== 1'b0 || ir_v[k] !== 1'b1 || dec_v[k] !== model_dec(x, k)) begin
                fails++;
                $display("FAIL release dut%0d: got ov=%b ir=%b dec=%h, want 0 1 %h",
                         k, ov_v[k], ir_v[k], dec_v[k], model_dec(x, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] x = 16'd54321;
        int seen = 0;
        int lat;
        bin_in   = 16'h9ABC;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dec_v[k] !== 20'h0 || neg_v[k] !== 1'b0 || ovf_v[k] !== 1'b0 || ov_v[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid dut%0d: got dec=%h neg=%b ovf=%b ov=%b, want all 0",
                         k, dec_v[k], neg_v[k], ovf_v[k], ov_v[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid0 || out_valid1 || out_valid2) seen++;
        end
        checks++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_output: got out_valid on %0d cycles, want 0", seen);
        end
        send_and_wait(x, 1'b0, lat);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dec_v[k] !== model_dec(x, k) || ovf_v[k] !== model_ovf(x, k) || neg_v[k] !== model_neg(x, k)) begin
                fails++;
                $display("FAIL after_reset dut%0d: got dec=%h ovf=%b neg=%b, want %h %b %b",
                         k, dec_v[k], ovf_v[k], neg_v[k], model_dec(x, k), model_ovf(x, k), model_neg(x, k));
            end
        end
        accept_result();
    endtask

    task automatic test_random_scoreboard();
        logic [15:0] x;
        int lat;
        for (int n = 0; n < 150; n++) begin
            x = 16'($urandom);
            if (n % 10 == 0) x = (n % 20 == 0) ? 16'h8000 : 16'd10000;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_and_wait(x, 1'($urandom_range(0, 1)), lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ov_v[k] !== 1'b1 || dec_v[k] !== model_dec(x, k) ||
                    ovf_v[k] !== model_ovf(x, k) || neg_v[k] !== model_neg(x, k)) begin
                    fails++;
                    $display("FAIL scoreboard dut%0d input %h: got ov=%b dec=%h ovf=%b neg=%b, want 1 %h %b %b",
                             k, x, ov_v[k], dec_v[k], ovf_v[k], neg_v[k],
                             model_dec(x, k), model_ovf(x, k), model_neg(x, k));
                end
            end
            accept_result();
        end
    endtask

    initial begin
        test_reset();
        test_examples();
        test_backpressure();
        test_reset_mid();
        test_random_scoreboard();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
